// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI4 read-channel encodings and the responder state enum.
// Ports: none (package only).
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_2B     = 3'b001;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        STREAM = 2'b10,
        DRAIN  = 2'b11
    } state_t;

    // Beats carry a single error bit internally; this expands it to rresp.
    function automatic logic [1:0] resp_of(input logic err);
        logic [1:0] resp;
        if (err) begin
            resp = RESP_SLVERR;
        end else begin
            resp = RESP_OKAY;
        end
        return resp;
    endfunction

endpackage

// File: rtl/axi_skid_buffer.sv
// ---------------------------------------------------------------------------
// axi_skid_buffer
// Two-entry valid/ready buffer: an output register plus one skid entry.
// The output register drives the AXI R channel directly, so all payload and
// valid outputs come straight from flops and hold while out_ready is low.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_data    push side (in_ready is low only when both entries full)
//   out_valid/out_data  pop side, out_ready from the consumer
//   count               number of occupied entries (0..2)
// ---------------------------------------------------------------------------
module axi_skid_buffer #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             skid_valid_r;
    logic [WIDTH-1:0] skid_data_r;
    logic             in_fire_s;
    logic             stall_s;

    // The skid entry is only ever filled while the output register is full.
    assign in_ready  = ~skid_valid_r;
    assign in_fire_s = in_valid & ~skid_valid_r;
    assign stall_s   = out_valid_r & ~out_ready;

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign count     = {1'b0, out_valid_r} + {1'b0, skid_valid_r};

    // Output/skid register update: park in skid on stall, refill from skid first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {WIDTH{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {WIDTH{1'b0}};
        end else if (stall_s) begin
            if (in_fire_s) begin
                skid_data_r  <= in_data;
                skid_valid_r <= 1'b1;
            end
        end else if (skid_valid_r) begin
            out_data_r   <= skid_data_r;
            out_valid_r  <= 1'b1;
            skid_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_fire_s;
            if (in_fire_s) begin
                out_data_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/axi_rd_responder.sv
// ---------------------------------------------------------------------------
// axi_rd_responder
// AXI4 read-channel slave backed by a synchronous single-port memory with
// 1-cycle read latency. One INCR burst of 2-byte beats at a time; beats are
// returned through a 2-entry skid buffer for 1 beat/cycle streaming.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   ar*_s_inf        AR channel (arready high only while idle)
//   r*_s_inf         R channel (rid/rdata/rresp/rlast/rvalid, rready in)
//   mem_en/mem_addr  memory read strobe and word address
//   mem_rdata        memory data, valid the cycle after mem_en
// ---------------------------------------------------------------------------
module axi_rd_responder
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_WORDS  = 4096,
    parameter int MEM_AW     = $clog2(MEM_WORDS),
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   arid_s_inf,
    input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
    input  logic [6:0]            arlen_s_inf,
    input  logic [2:0]            arsize_s_inf,
    input  logic [1:0]            arburst_s_inf,
    input  logic                  arvalid_s_inf,
    output logic                  arready_s_inf,
    output logic [ID_WIDTH-1:0]   rid_s_inf,
    output logic [DATA_WIDTH-1:0] rdata_s_inf,
    output logic [1:0]            rresp_s_inf,
    output logic                  rlast_s_inf,
    output logic                  rvalid_s_inf,
    input  logic                  rready_s_inf,
    output logic                  mem_en,
    output logic [MEM_AW-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int              PW        = DATA_WIDTH + 2;
    localparam logic [7:0]      WAIT_LOAD = 8'(LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

    // Last word of the burst must stay inside the memory; the full byte
    // address is used so high address bits cannot alias into range.
    function automatic logic range_err(input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [6:0]            len);
        logic [ADDR_WIDTH:0] last_word;
        last_word = {2'b00, addr[ADDR_WIDTH-1:1]} + {{(ADDR_WIDTH-6){1'b0}}, len};
        return (last_word >= MEM_LIMIT);
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic                arready_r;
    logic [ID_WIDTH-1:0] id_r;
    logic [7:0]          len_r;
    logic [MEM_AW-1:0]   start_r;
    logic                err_r;
    logic [7:0]          wait_r;
    logic [7:0]          cnt_r;
    logic                inflight_r;
    logic                inflight_last_r;

    logic                ar_hs_s;
    logic                err_s;
    logic                issue_s;
    logic                pop_s;
    logic                push_s;
    logic                room_s;
    logic [2:0]          occ_sum_s;
    logic [1:0]          occ_s;
    logic                skid_in_ready_s;
    logic [PW-1:0]       push_data_s;
    logic [PW-1:0]       out_data_s;
    logic                rvalid_s;

    assign ar_hs_s = arvalid_s_inf & arready_r;
    assign err_s   = (arsize_s_inf != SIZE_2B) | (arburst_s_inf != BURST_INCR)
                   | araddr_s_inf[0] | range_err(araddr_s_inf, arlen_s_inf);

    // Room counts the entry being popped this cycle as free; otherwise the
    // steady state (one beat held, one in flight) would insert a bubble.
    assign pop_s     = rvalid_s & rready_s_inf;
    assign occ_sum_s = {1'b0, occ_s} + {2'b00, inflight_r};
    assign room_s    = (occ_sum_s - {2'b00, pop_s}) < 3'd2;

    // Issue decision: one beat slot per cycle while streaming and room exists.
    always_comb begin
        issue_s = 1'b0;
        if ((state_r == STREAM) && room_s) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Error bursts consume beat slots with identical timing but never touch memory.
    assign mem_en   = issue_s & ~err_r;
    assign mem_addr = start_r + MEM_AW'(cnt_r);

    // Next-state logic for the burst sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (ar_hs_s) begin
                    if (LATENCY == 0) begin
                        state_s = STREAM;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (wait_r == 8'd0) begin
                    state_s = STREAM;
                end else begin
                    state_s = WAIT;
                end
            end
            STREAM: begin
                if (issue_s && (cnt_r == len_r)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = STREAM;
                end
            end
            DRAIN: begin
                if (pop_s && rlast_s_inf) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register; arready is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            arready_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            arready_r <= (state_s == IDLE);
        end
    end

    // Burst context captured at AR accept; wait and issue counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_r    <= {ID_WIDTH{1'b0}};
            len_r   <= 8'd0;
            start_r <= {MEM_AW{1'b0}};
            err_r   <= 1'b0;
            wait_r  <= 8'd0;
            cnt_r   <= 8'd0;
        end else if (ar_hs_s) begin
            id_r    <= arid_s_inf;
            len_r   <= {1'b0, arlen_s_inf};
            start_r <= araddr_s_inf[MEM_AW:1];
            err_r   <= err_s;
            wait_r  <= WAIT_LOAD;
            cnt_r   <= 8'd0;
        end else begin
            if ((state_r == WAIT) && (wait_r != 8'd0)) begin
                wait_r <= wait_r - 8'd1;
            end
            if (issue_s) begin
                cnt_r <= cnt_r + 8'd1;
            end
        end
    end

    // Tracks the beat whose memory word arrives next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s & (cnt_r == len_r);
        end
    end

    // Room accounting guarantees in_ready whenever a word lands.
    assign push_s      = inflight_r & skid_in_ready_s;
    assign push_data_s = {err_r, inflight_last_r, (err_r ? {DATA_WIDTH{1'b0}} : mem_rdata)};

    axi_skid_buffer #(
        .WIDTH(PW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (push_s),
        .in_data  (push_data_s),
        .in_ready (skid_in_ready_s),
        .out_valid(rvalid_s),
        .out_data (out_data_s),
        .out_ready(rready_s_inf),
        .count    (occ_s)
    );

    assign arready_s_inf = arready_r;
    assign rid_s_inf     = id_r;
    assign rvalid_s_inf  = rvalid_s;
    assign rdata_s_inf   = out_data_s[DATA_WIDTH-1:0];
    assign rlast_s_inf   = out_data_s[DATA_WIDTH];
    assign rresp_s_inf   = resp_of(out_data_s[DATA_WIDTH+1]);

endmodule

// File: tb/tb_axi_rd_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_responder
// Self-checking bench for axi_rd_responder: directed scenarios plus
// randomized bursts compared against a burst-level reference model.
// ---------------------------------------------------------------------------
module tb_axi_rd_responder;

    localparam int LAT   = 4;
    localparam int WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  arid = 4'h0;
    logic [31:0] araddr = 32'h0;
    logic [6:0]  arlen = 7'd0;
    logic [2:0]  arsize = 3'b001;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [15:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0;

    logic [15:0] mem [0:WORDS-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_en_cnt = 0;

    // burst collection results
    logic [15:0] got_data [0:129];
    logic        got_last [0:129];
    logic [1:0]  got_resp [0:129];
    logic [3:0]  got_id   [0:129];
    int          got_cyc  [0:129];
    int n_beats, first_rv, hs_edge, stall_bad, last_edge, me_cnt;
    bit ar_seen_high;
    logic arready_after;

    // reference model results
    logic [15:0] exp_data [0:129];
    logic        exp_last [0:129];
    logic [1:0]  exp_resp [0:129];
    logic [3:0]  exp_id;
    int          exp_n;
    bit          exp_err;

    always #5 clk = ~clk;

    axi_rd_responder #(
        .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(16),
        .MEM_WORDS(WORDS), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .arid_s_inf(arid), .araddr_s_inf(araddr), .arlen_s_inf(arlen),
        .arsize_s_inf(arsize), .arburst_s_inf(arburst),
        .arvalid_s_inf(arvalid), .arready_s_inf(arready),
        .rid_s_inf(rid), .rdata_s_inf(rdata), .rresp_s_inf(rresp),
        .rlast_s_inf(rlast), .rvalid_s_inf(rvalid), .rready_s_inf(rready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    // Memory model with 1-cycle read latency; cycle and strobe counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en === 1'b1) begin
            mem_rdata  <= mem[mem_addr];
            mem_en_cnt <= mem_en_cnt + 1;
        end
    end

    // Reference model: what an AXI INCR burst of 2-byte beats must return.
    task automatic build_expected(input logic [3:0] id, input logic [31:0] addr,
                                  input logic [6:0] len, input logic [2:0] size,
                                  input logic [1:0] burst);
        longint word;
        word    = longint'(addr >> 1);
        exp_err = (size != 3'b001) || (burst != 2'b01) || (addr[0] == 1'b1)
               || (word + longint'(len) >= longint'(WORDS));
        exp_n   = int'(len) + 1;
        exp_id  = id;
        for (int i = 0; i < exp_n; i++) begin
            if (exp_err) begin
                exp_data[i] = 16'h0000;
                exp_resp[i] = 2'b10;
            end else begin
                exp_data[i] = mem[int'(word) + i];
                exp_resp[i] = 2'b00;
            end
            exp_last[i] = (i == exp_n - 1);
        end
    endtask

    // Drives one AR request and collects R beats; called and returns at a negedge.
    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr,
                             input logic [6:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int mode,
                             input int abort_after, input bit hold_next);
        int guard; int phase; int me0; bit done; bit prev_stall;
        logic [15:0] pd; logic pl; logic [1:0] pr;
        n_beats = 0; first_rv = -1; stall_bad = 0; ar_seen_high = 1'b0;
        done = 1'b0; prev_stall = 1'b0; phase = 0; pd = 16'h0; pl = 1'b0; pr = 2'b00;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        guard = 0;
        while (arready !== 1'b1 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (arready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ar_accept_timeout: arready=%b required 1", arready);
            arvalid = 1'b0;
            return;
        end
        hs_edge = cyc + 1;
        me0 = mem_en_cnt;
        @(negedge clk);
        if (hold_next) begin
            arid = 4'h5; araddr = 32'h0000_0020; arlen = 7'd0;
            arsize = 3'b001; arburst = 2'b01;
        end else begin
            arvalid = 1'b0;
        end
        guard = 0;
        while (!done && guard < 2000) begin
            case (mode)
                0: rready = 1'b1;
                1: rready = ((phase % 4) == 0) || ((phase % 4) == 3);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            phase++;
            if (arready === 1'b1) ar_seen_high = 1'b1;
            if (prev_stall && (rvalid !== 1'b1 || rdata !== pd || rlast !== pl || rresp !== pr))
                stall_bad++;
            if (rvalid === 1'b1 && first_rv < 0) first_rv = cyc;
            if (rvalid === 1'b1 && rready === 1'b1) begin
                got_data[n_beats] = rdata; got_last[n_beats] = rlast;
                got_resp[n_beats] = rresp; got_id[n_beats] = rid;
                got_cyc[n_beats] = cyc;
                n_beats++;
                if (rlast === 1'b1 || n_beats == abort_after || n_beats >= 129) done = 1'b1;
            end
            prev_stall = (rvalid === 1'b1) && (rready !== 1'b1);
            pd = rdata; pl = rlast; pr = rresp;
            @(negedge clk);
            guard++;
        end
        last_edge     = cyc;
        arready_after = arready;
        me_cnt        = mem_en_cnt - me0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL r_timeout: beats=%0d required %0d", n_beats, int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({arready, rvalid, rlast, rid, rdata, rresp, mem_en, mem_addr} !==
            {1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 12'h0}) begin
            errors++;
            $display("FAIL reset_values: arready=%b rvalid=%b rlast=%b rid=%h rdata=%h rresp=%b mem_en=%b mem_addr=%h required 1 0 0 0 0000 00 0 000",
                     arready, rvalid, rlast, rid, rdata, rresp, mem_en, mem_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: arready=%b rvalid=%b required 1 0", arready, rvalid);
        end
    endtask

    task automatic test_burst();
        build_expected(4'h3, 32'h0000_0010, 7'd7, 3'b001, 2'b01);
        run_burst(4'h3, 32'h0000_0010, 7'd7, 3'b001, 2'b01, 0, -1, 1'b0);
        checks++;
        if (n_beats != 8) begin errors++; $display("FAIL burst_count: got %0d required 8", n_beats); end
        for (int i = 0; i < exp_n && i < n_beats; i++) begin
            checks++;
            if (got_data[i] !== 16'(24 + 3 * i) || got_last[i] !== exp_last[i] ||
                got_resp[i] !== 2'b00 || got_id[i] !== 4'h3) begin
                errors++;
                $display("FAIL burst_beat%0d: got data=%0d last=%b resp=%b id=%h required data=%0d last=%b resp=00 id=3",
                         i, got_data[i], got_last[i], got_resp[i], got_id[i], 24 + 3 * i, exp_last[i]);
            end
        end
        checks++;
        if (first_rv - hs_edge != LAT + 2) begin
            errors++; $display("FAIL burst_latency: got %0d edges required %0d", first_rv - hs_edge, LAT + 2);
        end
        checks++;
        if (n_beats == 8 && got_cyc[7] - got_cyc[0] != 7) begin
            errors++; $display("FAIL burst_throughput: span %0d required 7", got_cyc[7] - got_cyc[0]);
        end
        checks++;
        if (me_cnt != 8) begin errors++; $display("FAIL burst_mem_en: got %0d required 8", me_cnt); end
        checks++;
        if (arready_after !== 1'b1 || ar_seen_high) begin
            errors++; $display("FAIL burst_arready: after=%b seen_during=%0b required 1 0", arready_after, ar_seen_high);
        end
    endtask

    task automatic test_backpressure();
        build_expected(4'h3, 32'h0000_0010, 7'd7, 3'b001, 2'b01);
        run_burst(4'h3, 32'h0000_0010, 7'd7, 3'b001, 2'b01, 1, -1, 1'b0);
        checks++;
        if (n_beats != 8) begin errors++; $display("FAIL bp_count: got %0d required 8", n_beats); end
        for (int i = 0; i < exp_n && i < n_beats; i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_resp[i] !== exp_resp[i]) begin
                errors++;
                $display("FAIL bp_beat%0d: got data=%h last=%b resp=%b required data=%h last=%b resp=%b",
                         i, got_data[i], got_last[i], got_resp[i], exp_data[i], exp_last[i], exp_resp[i]);
            end
        end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable stalls required 0", stall_bad); end
    endtask

    task automatic test_bad_size();
        run_burst(4'h7, 32'h0000_0040, 7'd3, 3'b010, 2'b01, 0, -1, 1'b0);
        checks++;
        if (n_beats != 4) begin errors++; $display("FAIL size_count: got %0d required 4", n_beats); end
        for (int i = 0; i < n_beats && i < 4; i++) begin
            checks++;
            if (got_resp[i] !== 2'b10 || got_data[i] !== 16'h0 || got_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL size_beat%0d: got resp=%b data=%h last=%b required 10 0000 %0b",
                         i, got_resp[i], got_data[i], got_last[i], (i == 3));
            end
        end
        checks++;
        if (me_cnt != 0) begin errors++; $display("FAIL size_mem_en: got %0d required 0", me_cnt); end
        checks++;
        if (first_rv - hs_edge != LAT + 2) begin
            errors++; $display("FAIL size_latency: got %0d required %0d", first_rv - hs_edge, LAT + 2);
        end
    endtask

    task automatic test_range();
        run_burst(4'h1, 32'h0000_1FFC, 7'd2, 3'b001, 2'b01, 0, -1, 1'b0);
        checks++;
        if (n_beats != 3) begin errors++; $display("FAIL range_err_count: got %0d required 3", n_beats); end
        for (int i = 0; i < n_beats && i < 3; i++) begin
            checks++;
            if (got_resp[i] !== 2'b10 || got_data[i] !== 16'h0) begin
                errors++; $display("FAIL range_err_beat%0d: got resp=%b data=%h required 10 0000", i, got_resp[i], got_data[i]);
            end
        end
        checks++;
        if (me_cnt != 0) begin errors++; $display("FAIL range_err_mem_en: got %0d required 0", me_cnt); end
        run_burst(4'h2, 32'h0000_1FFC, 7'd1, 3'b001, 2'b01, 0, -1, 1'b0);
        checks++;
        if (n_beats != 2) begin errors++; $display("FAIL range_ok_count: got %0d required 2", n_beats); end
        for (int i = 0; i < n_beats && i < 2; i++) begin
            checks++;
            if (got_resp[i] !== 2'b00 || got_data[i] !== 16'(3 * (4094 + i))) begin
                errors++;
                $display("FAIL range_ok_beat%0d: got resp=%b data=%0d required 00 %0d", i, got_resp[i], got_data[i], 3 * (4094 + i));
            end
        end
    endtask

    task automatic test_arid();
        int first_end;
        run_burst(4'hA, 32'h0000_0100, 7'd0, 3'b001, 2'b01, 0, -1, 1'b1);
        first_end = last_edge;
        checks++;
        if (n_beats != 1 || got_id[0] !== 4'hA || got_last[0] !== 1'b1 || got_data[0] !== 16'(3 * 128)) begin
            errors++;
            $display("FAIL arid_beat: got n=%0d id=%h last=%b data=%0d required 1 a 1 384",
                     n_beats, got_id[0], got_last[0], got_data[0]);
        end
        checks++;
        if (arready_after !== 1'b1 || ar_seen_high) begin
            errors++; $display("FAIL arid_arready: after=%b seen_during=%0b required 1 0", arready_after, ar_seen_high);
        end
        run_burst(4'h5, 32'h0000_0020, 7'd0, 3'b001, 2'b01, 0, -1, 1'b0);
        checks++;
        if (hs_edge != first_end + 1) begin
            errors++; $display("FAIL held_ar_accept: edge %0d required %0d", hs_edge, first_end + 1);
        end
        checks++;
        if (n_beats != 1 || got_id[0] !== 4'h5 || got_data[0] !== 16'(3 * 16)) begin
            errors++; $display("FAIL held_ar_beat: got n=%0d id=%h data=%0d required 1 5 48", n_beats, got_id[0], got_data[0]);
        end
    endtask

    task automatic test_reset_mid_burst();
        run_burst(4'h6, 32'h0000_0010, 7'd7, 3'b001, 2'b01, 0, 2, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({arready, rvalid, rlast, rid, rdata, rresp, mem_en, mem_addr} !==
            {1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 12'h0}) begin
            errors++;
            $display("FAIL midreset_values: arready=%b rvalid=%b rlast=%b rid=%h rdata=%h rresp=%b mem_en=%b mem_addr=%h required 1 0 0 0 0000 00 0 000",
                     arready, rvalid, rlast, rid, rdata, rresp, mem_en, mem_addr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL midreset_hold: rvalid=%b required 0", rvalid); end
        rst_n = 1'b1;
        @(negedge clk);
        build_expected(4'h9, 32'h0000_0030, 7'd5, 3'b001, 2'b01);
        run_burst(4'h9, 32'h0000_0030, 7'd5, 3'b001, 2'b01, 0, -1, 1'b0);
        checks++;
        if (n_beats != exp_n) begin errors++; $display("FAIL midreset_count: got %0d required %0d", n_beats, exp_n); end
        for (int i = 0; i < exp_n && i < n_beats; i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_resp[i] !== exp_resp[i]) begin
                errors++;
                $display("FAIL midreset_beat%0d: got data=%h last=%b resp=%b required %h %b %b",
                         i, got_data[i], got_last[i], got_resp[i], exp_data[i], exp_last[i], exp_resp[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] id; logic [31:0] addr; logic [6:0] len; logic [2:0] size; logic [1:0] burst;
        int mode; int sel;
        for (int k = 0; k < WORDS; k++) mem[k] = 16'($urandom);
        for (int n = 0; n < 40; n++) begin
            id = 4'($urandom); size = 3'b001; burst = 2'b01; mode = $urandom_range(0, 2);
            len = (n == 0) ? 7'd127 : ($urandom_range(0, 9) == 0 ? 7'($urandom) : 7'($urandom_range(0, 15)));
            addr = (n == 0) ? 32'h0 : {19'h0, 12'($urandom), 1'b0};
            sel = $urandom_range(0, 9);
            if (sel == 0) addr[0] = 1'b1;
            else if (sel == 1) size = 3'($urandom_range(2, 7));
            else if (sel == 2) burst = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
            else if (sel == 3) addr = 32'(2 * (WORDS - $urandom_range(1, 20)));
            else if (sel == 4) addr = 32'h0001_0000;
            build_expected(id, addr, len, size, burst);
            run_burst(id, addr, len, size, burst, mode, -1, 1'b0);
            checks++;
            if (n_beats != exp_n) begin
                errors++; $display("FAIL rnd%0d_count: got %0d required %0d", n, n_beats, exp_n);
            end
            for (int i = 0; i < exp_n && i < n_beats; i++) begin
                checks++;
                if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] ||
                    got_resp[i] !== exp_resp[i] || got_id[i] !== exp_id) begin
                    errors++;
                    $display("FAIL rnd%0d_beat%0d: got data=%h last=%b resp=%b id=%h required %h %b %b %h",
                             n, i, got_data[i], got_last[i], got_resp[i], got_id[i],
                             exp_data[i], exp_last[i], exp_resp[i], exp_id);
                end
            end
            checks++;
            if (first_rv - hs_edge != LAT + 2 || stall_bad != 0 || arready_after !== 1'b1 || ar_seen_high) begin
                errors++;
                $display("FAIL rnd%0d_timing: latency=%0d stalls_bad=%0d arready_after=%b seen=%0b required %0d 0 1 0",
                         n, first_rv - hs_edge, stall_bad, arready_after, ar_seen_high, LAT + 2);
            end
            checks++;
            if (me_cnt != (exp_err ? 0 : exp_n)) begin
                errors++; $display("FAIL rnd%0d_mem_en: got %0d required %0d", n, me_cnt, exp_err ? 0 : exp_n);
            end
            if (mode == 0 && n_beats == exp_n) begin
                checks++;
                if (got_cyc[n_beats - 1] - got_cyc[0] != exp_n - 1) begin
                    errors++; $display("FAIL rnd%0d_throughput: span %0d required %0d", n, got_cyc[n_beats - 1] - got_cyc[0], exp_n - 1);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < WORDS; k++) mem[k] = 16'(k * 3);
        test_reset();
        test_burst();
        test_backpressure();
        test_bad_size();
        test_range();
        test_arid();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
